// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the main-memory bus arbiter.
// Used by the interface, the round-robin picker and the arbiter top.
package mem_bus_pkg;

   localparam int DEF_NUM_REQ   = 2;   // dual-core
   localparam int DEF_BURST_LEN = 4;   // 32-bit words per 16-byte line
   localparam int DEF_ADDR_W    = 32;  // byte address width
   localparam int DEF_OFF_W     = 4;   // line byte-offset bits

   // Arbiter sequencing: decide, move the line, acknowledge
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   // Direction of the line transfer, taken from wr_req of the winner
   typedef enum logic {
      OP_FILL     = 1'b0,
      OP_COPYBACK = 1'b1
   } bus_op_t;

   // Width of an index selecting one of n items; never narrower than 1 bit
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus between the per-core cache controllers, the arbiter and main memory.
// The master modport is the arbiter; the slave modport is the cache/memory side.
// Snoop broadcast signals exist only when SNOOP_BCAST_EN is defined.
interface mem_bus_arbiter_if
   import mem_bus_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int OFF_W     = DEF_OFF_W
) ();

   localparam int LINE_W = ADDR_W - OFF_W;
   localparam int WSEL_W = sel_width(BURST_LEN);

   // Requester side
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             wr_req;
   logic [NUM_REQ-1:0][LINE_W-1:0] line_addr;
   logic [NUM_REQ-1:0]             rd_intent_req;
   logic [NUM_REQ-1:0]             wr_intent_req;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             done;

   // Memory side
   logic [WSEL_W-1:0]              w_sel;
   logic                           mem_rd;
   logic                           mem_wr;
   logic [ADDR_W-1:0]              mem_addr;
   logic                           mem_ready;

`ifdef SNOOP_BCAST_EN
   logic                           snoop_valid;
   logic [NUM_REQ-1:0]             snoop_src;
   logic [LINE_W-1:0]              snoop_addr;
   logic                           snoop_rd_intent;
   logic                           snoop_wr_intent;

   modport master (
      input  req, wr_req, line_addr, rd_intent_req, wr_intent_req, mem_ready,
      output gnt, done, w_sel, mem_rd, mem_wr, mem_addr,
             snoop_valid, snoop_src, snoop_addr, snoop_rd_intent, snoop_wr_intent
   );

   modport slave (
      output req, wr_req, line_addr, rd_intent_req, wr_intent_req, mem_ready,
      input  gnt, done, w_sel, mem_rd, mem_wr, mem_addr,
             snoop_valid, snoop_src, snoop_addr, snoop_rd_intent, snoop_wr_intent
   );
`else
   modport master (
      input  req, wr_req, line_addr, rd_intent_req, wr_intent_req, mem_ready,
      output gnt, done, w_sel, mem_rd, mem_wr, mem_addr
   );

   modport slave (
      output req, wr_req, line_addr, rd_intent_req, wr_intent_req, mem_ready,
      input  gnt, done, w_sel, mem_rd, mem_wr, mem_addr
   );
`endif

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the pointer
// and wraps, so the most recent winner has the lowest priority.
// The pointer register itself lives in the arbiter top.
module rr_arbiter
   import mem_bus_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int PTR_W  = sel_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_idx
);

   int               w_sum;
   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // Walk the requesters from pointer+1 and take the first one asserted
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = 0;
      w_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_sum = int'(i_ptr) + i;
         if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
         end
         w_idx = PTR_W'(w_sum);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_idx        = w_idx;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Main-memory bus arbiter for NUM_REQ data-cache controllers.
// Grants one controller at a time (round-robin), then sequences a
// BURST_LEN-word line fill or copy-back, driving w_sel, mem_addr and
// the read/write strobes. Data muxing is external and steered by gnt.
// Optional feature: define SNOOP_BCAST_EN to add a one-cycle MSI snoop
// broadcast at the start of each transfer.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int OFF_W     = DEF_OFF_W
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_bus_arbiter_if.master bus
);

   localparam int LINE_W = ADDR_W - OFF_W;
   localparam int WSEL_W = sel_width(BURST_LEN);
   localparam int PTR_W  = sel_width(NUM_REQ);
   localparam int PAD_W  = OFF_W - WSEL_W;   // byte-in-word bits below w_sel

   localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(BURST_LEN - 1);
   localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(NUM_REQ - 1);  // requester 0 wins first

   arb_state_t           r_state;
   logic [PTR_W-1:0]     r_ptr;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   r_done;
   logic [WSEL_W-1:0]    r_wsel;
   logic                 r_mem_rd;
   logic                 r_mem_wr;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [LINE_W-1:0]    r_line;

   logic [NUM_REQ-1:0]   w_pick_gnt;
   logic [PTR_W-1:0]     w_pick_idx;
   logic [LINE_W-1:0]    w_pick_line;
   bus_op_t              w_pick_op;
   logic [WSEL_W-1:0]    w_next_sel;

`ifdef SNOOP_BCAST_EN
   logic                 r_snoop_valid;
   logic [NUM_REQ-1:0]   r_snoop_src;
   logic [LINE_W-1:0]    r_snoop_addr;
   logic                 r_snoop_rd;
   logic                 r_snoop_wr;
`else
   // Intent inputs only matter to the snoop broadcast
   logic                 w_unused_intent;
   assign w_unused_intent = ^{bus.rd_intent_req, bus.wr_intent_req};
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx)
   );

   assign w_pick_line = bus.line_addr[w_pick_idx];
   assign w_pick_op   = bus.wr_req[w_pick_idx] ? OP_COPYBACK : OP_FILL;
   assign w_next_sel  = r_wsel + WSEL_W'(1);

   // Arbitration and burst sequencing FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_ptr      <= PTR_INIT;
         r_gnt      <= '0;
         r_done     <= '0;
         r_wsel     <= '0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_mem_addr <= '0;
         r_line     <= '0;
`ifdef SNOOP_BCAST_EN
         r_snoop_valid <= 1'b0;
         r_snoop_src   <= '0;
         r_snoop_addr  <= '0;
         r_snoop_rd    <= 1'b0;
         r_snoop_wr    <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
         case (r_state)
            IDLE: begin
               if (|bus.req) begin
                  r_state    <= XFER;
                  r_ptr      <= w_pick_idx;
                  r_gnt      <= w_pick_gnt;
                  r_line     <= w_pick_line;
                  r_wsel     <= '0;
                  r_mem_rd   <= (w_pick_op == OP_FILL);
                  r_mem_wr   <= (w_pick_op == OP_COPYBACK);
                  r_mem_addr <= {w_pick_line, {WSEL_W{1'b0}}, {PAD_W{1'b0}}};
`ifdef SNOOP_BCAST_EN
                  r_snoop_valid <= 1'b1;
                  r_snoop_src   <= w_pick_gnt;
                  r_snoop_addr  <= w_pick_line;
                  r_snoop_rd    <= bus.rd_intent_req[w_pick_idx];
                  r_snoop_wr    <= bus.wr_intent_req[w_pick_idx];
`endif
               end
            end

            XFER: begin
`ifdef SNOOP_BCAST_EN
               // Broadcast lasts only the first transfer cycle, stall or not
               r_snoop_valid <= 1'b0;
               r_snoop_src   <= '0;
               r_snoop_addr  <= '0;
               r_snoop_rd    <= 1'b0;
               r_snoop_wr    <= 1'b0;
`endif
               if (bus.mem_ready) begin
                  if (r_wsel == LAST_BEAT) begin
                     r_state    <= DONE;
                     r_mem_rd   <= 1'b0;
                     r_mem_wr   <= 1'b0;
                     r_mem_addr <= '0;
                     r_done     <= r_gnt;
                  end else begin
                     r_wsel     <= w_next_sel;
                     r_mem_addr <= {r_line, w_next_sel, {PAD_W{1'b0}}};
                  end
               end
            end

            DONE: begin
               r_state <= IDLE;
               r_done  <= '0;
               r_gnt   <= '0;
               r_wsel  <= '0;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.done     = r_done;
   assign bus.w_sel    = r_wsel;
   assign bus.mem_rd   = r_mem_rd;
   assign bus.mem_wr   = r_mem_wr;
   assign bus.mem_addr = r_mem_addr;

`ifdef SNOOP_BCAST_EN
   assign bus.snoop_valid     = r_snoop_valid;
   assign bus.snoop_src       = r_snoop_src;
   assign bus.snoop_addr      = r_snoop_addr;
   assign bus.snoop_rd_intent = r_snoop_rd;
   assign bus.snoop_wr_intent = r_snoop_wr;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (dual-core, 4-word lines).
// Outputs are sampled 1 time unit after the rising edge; inputs are driven
// at the same point so they take effect at the following edge.
// The snoop scenario is compiled in when SNOOP_BCAST_EN is defined.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int NR = 2;
   localparam int BL = 4;
   localparam int AW = 32;
   localparam int OW = 4;

   logic clk = 1'b0;
   logic reset_n;

   int n_pass  = 0;
   int n_total = 0;
   int n_done  = 0;

   // Copy-back stall scenario: mem_ready per transfer cycle and expected w_sel/addr
   int                pat_ready[7] = '{1, 0, 0, 1, 1, 0, 1};
   int                exp_ws[7]    = '{0, 1, 1, 1, 2, 3, 3};
   logic [31:0]       exp_cb[7]    = '{32'hABC0, 32'hABC4, 32'hABC4, 32'hABC4,
                                       32'hABC8, 32'hABCC, 32'hABCC};
   logic [31:0]       exp_fill[4]  = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};

   mem_bus_arbiter_if #(
      .NUM_REQ(NR), .BURST_LEN(BL), .ADDR_W(AW), .OFF_W(OW)
   ) bus ();

   mem_bus_arbiter #(
      .NUM_REQ(NR), .BURST_LEN(BL), .ADDR_W(AW), .OFF_W(OW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Step until done appears (bounded); the grant must still be held then
   task automatic wait_done(input string tag, input logic [1:0] exp_gnt);
      int n;
      n = 0;
      while (bus.done == '0 && n < 40) begin
         step();
         n++;
      end
      check({tag, "_done"}, 64'(bus.done), 64'(exp_gnt));
      check({tag, "_gnt"},  64'(bus.gnt),  64'(exp_gnt));
      check({tag, "_strb"}, 64'({bus.mem_rd, bus.mem_wr}), 64'h0);
   endtask

   initial begin
      reset_n           = 1'b0;
      bus.req           = '0;
      bus.wr_req        = '0;
      bus.line_addr     = '0;
      bus.rd_intent_req = '0;
      bus.wr_intent_req = '0;
      bus.mem_ready     = 1'b0;

      // ---- reset state ----
      #12;
      check("rst_gnt",  64'(bus.gnt),      64'h0);
      check("rst_done", 64'(bus.done),     64'h0);
      check("rst_wsel", 64'(bus.w_sel),    64'h0);
      check("rst_strb", 64'({bus.mem_rd, bus.mem_wr}), 64'h0);
      check("rst_addr", 64'(bus.mem_addr), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // ---- single fill, core0, line 0x1230, no stalls ----
      bus.req          = 2'b01;
      bus.line_addr[0] = 28'h0000_123;
      bus.mem_ready    = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fill_gnt%0d", k),  64'(bus.gnt),      64'h1);
         check($sformatf("fill_rd%0d", k),   64'(bus.mem_rd),   64'h1);
         check($sformatf("fill_addr%0d", k), 64'(bus.mem_addr), 64'(exp_fill[k]));
         check($sformatf("fill_ws%0d", k),   64'(bus.w_sel),    64'(k));
         check($sformatf("fill_dn%0d", k),   64'(bus.done),     64'h0);
         step();
      end
      check("fill_done",   64'(bus.done),     64'h1);
      check("fill_dgnt",   64'(bus.gnt),      64'h1);
      check("fill_rd_off", 64'(bus.mem_rd),   64'h0);
      check("fill_addr0",  64'(bus.mem_addr), 64'h0);
      bus.req = 2'b00;
      step();
      check("fill_idle_gnt",  64'(bus.gnt),  64'h0);
      check("fill_idle_done", 64'(bus.done), 64'h0);

      // ---- contest after reset: core0, then core1, then core0 again ----
      pulse_reset();
      bus.req          = 2'b11;
      bus.line_addr[0] = 28'h100;
      bus.line_addr[1] = 28'h200;
      step();
      check("ct_first", 64'(bus.gnt), 64'h1);
      wait_done("ct_c0", 2'b01);
      bus.req = 2'b10;
      step();
      check("ct_gap", 64'(bus.gnt), 64'h0);
      step();
      check("ct_second",  64'(bus.gnt),      64'h2);
      check("ct_sec_adr", 64'(bus.mem_addr), 64'h2000);
      wait_done("ct_c1", 2'b10);
      bus.req = 2'b11;
      step();
      step();
      check("ct_third", 64'(bus.gnt), 64'h1);
      wait_done("ct_c0b", 2'b01);
      bus.req = 2'b00;
      step();

      // ---- copy-back by core1 with stalls ----
      bus.req          = 2'b10;
      bus.wr_req       = 2'b10;
      bus.line_addr[1] = 28'hABC;
      bus.mem_ready    = 1'b1;
      n_done           = 0;
      step();
      for (int k = 0; k < 7; k++) begin
         check($sformatf("cb_ws%0d", k),   64'(bus.w_sel),    64'(exp_ws[k]));
         check($sformatf("cb_wr%0d", k),   64'({bus.mem_rd, bus.mem_wr}), 64'h1);
         check($sformatf("cb_gnt%0d", k),  64'(bus.gnt),      64'h2);
         check($sformatf("cb_addr%0d", k), 64'(bus.mem_addr), 64'(exp_cb[k]));
         if (bus.done != '0) n_done++;
         bus.mem_ready = (pat_ready[k] != 0);
         step();
      end
      check("cb_done",   64'(bus.done),   64'h2);
      check("cb_wr_off", 64'(bus.mem_wr), 64'h0);
      if (bus.done != '0) n_done++;
      bus.req       = 2'b00;
      bus.wr_req    = 2'b00;
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (bus.done != '0) n_done++;
      end
      check("cb_one_done", 64'(n_done), 64'h1);

      // ---- core0 drops req after beat 2: burst still completes ----
      bus.req          = 2'b01;
      bus.line_addr[0] = 28'h055;
      step();
      step();
      step();
      check("drop_ws", 64'(bus.w_sel), 64'h2);
      bus.req = 2'b00;
      wait_done("drop", 2'b01);
      step();
      check("drop_idle", 64'(bus.gnt), 64'h0);

      // ---- async reset during beat 3 of a core1 fill ----
      bus.req          = 2'b10;
      bus.line_addr[1] = 28'h077;
      step();
      check("ar_gnt", 64'(bus.gnt), 64'h2);
      step();
      step();
      check("ar_ws2", 64'(bus.w_sel), 64'h2);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_gnt0",  64'(bus.gnt),      64'h0);
      check("ar_done0", 64'(bus.done),     64'h0);
      check("ar_strb0", 64'({bus.mem_rd, bus.mem_wr}), 64'h0);
      check("ar_addr0", 64'(bus.mem_addr), 64'h0);
      check("ar_ws0",   64'(bus.w_sel),    64'h0);
      step();
      check("ar_hold_done", 64'(bus.done), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      check("ar_regnt", 64'(bus.gnt),      64'h2);
      check("ar_rerd",  64'(bus.mem_rd),   64'h1);
      check("ar_readr", 64'(bus.mem_addr), 64'h770);
      wait_done("ar_post", 2'b10);
      bus.req = 2'b00;
      step();

`ifdef SNOOP_BCAST_EN
      // ---- snoop broadcast: core0 fill with write intent at line 0x40 ----
      pulse_reset();
      bus.req           = 2'b01;
      bus.wr_intent_req = 2'b01;
      bus.line_addr[0]  = 28'h40;
      step();
      check("sn_valid", 64'(bus.snoop_valid),     64'h1);
      check("sn_src",   64'(bus.snoop_src),       64'h1);
      check("sn_addr",  64'(bus.snoop_addr),      64'h40);
      check("sn_wr",    64'(bus.snoop_wr_intent), 64'h1);
      check("sn_rd",    64'(bus.snoop_rd_intent), 64'h0);
      check("sn_memrd", 64'(bus.mem_rd),          64'h1);
      step();
      check("sn_valid_off", 64'(bus.snoop_valid), 64'h0);
      wait_done("sn", 2'b01);
      bus.req           = 2'b00;
      bus.wr_intent_req = 2'b00;
      step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Last-resort bound on total run time
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
